dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, cycles without mem_ack before an access is aborted (legal range 1..255).
REQ-002 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RSTn  input  1  asynchronous, active-low reset.
REQ-004 Port: InstReqF  input  1  fetch requests an instruction word; held until InstValidF.
REQ-005 Port: PCF  input  32  fetch address.
REQ-006 Port: InstrF  output  32  fetched instruction word.
REQ-007 Port: InstValidF  output  1  one-cycle pulse; InstrF is valid in this cycle.
REQ-008 Port: MemReadM, MemWriteM  input  1 each  MEM-stage load and store requests; held until DataDoneM.
REQ-009 Port: ALUresultM  input  32  data address.
REQ-010 Port: WriteDataM  input  32  store data.
REQ-011 Port: ReadDataM  output  32  load result.
REQ-012 Port: DataDoneM  output  1  one-cycle pulse; data access complete.
REQ-013 Port: StallM  output  1  combinational; equals (MemReadM|MemWriteM) & ~DataDoneM.
REQ-014 Ports: mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each; unified single-port memory request.
REQ-015 Ports: mem_ack  input  1; mem_rdata  input  32; memory completion and read data.
REQ-016 Port: BusErr  output  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, INST, DATA and RESP.
REQ-018 IDLE arbitration SHALL work as follows: with one request pending, grant it; with both pending, grant the requester not served last (flag last_data, reset 0, so data wins the first tie).
REQ-019 On a grant, PCF or ALUresultM, WriteDataM and the write flag SHALL be registered; the FSM SHALL enter INST or DATA; mem_req=1 from the next cycle.
REQ-020 mem_addr, mem_we and mem_wdata SHALL be driven from registers and held stable while mem_req=1.
REQ-021 mem_we SHALL be 1 only in DATA with MemWriteM captured; if MemReadM and MemWriteM are both set, the access is a write.
REQ-022 In INST or DATA, mem_ack sampled high SHALL capture mem_rdata, drop mem_req and move the FSM to RESP.
REQ-023 RESP SHALL last exactly one cycle, pulse InstValidF or DataDoneM, issue no grant, then return to IDLE.
REQ-024 Minimum latency: request in cycle 0, mem_req in cycle 1, ack in cycle 1, done pulse in cycle 2, next grant possible in cycle 3.
REQ-025 InstrF and ReadDataM SHALL update only in RESP for their own requester and otherwise hold their value; a write SHALL leave ReadDataM unchanged.
REQ-026 A wait counter (8 bits) SHALL clear on entry to INST or DATA and increment each cycle without ack.
REQ-027 When the counter reaches TIMEOUT-1 without ack, the block SHALL drop mem_req, set BusErr, load 0 into the target data register and enter RESP, completing normally.
REQ-028 An ack and a timeout in the same cycle SHALL be treated as an ack; BusErr is not set.
REQ-029 mem_ack SHALL be ignored in IDLE and RESP.
REQ-030 A request deasserted mid-access (protocol violation) SHALL not abort the access; the done pulse is still issued.
REQ-031 last_data SHALL update when entering RESP: 1 for a data access, 0 for a fetch.

Reset
REQ-032 RSTn low SHALL immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, InstrF=0, ReadDataM=0, InstValidF=0, DataDoneM=0, BusErr=0, counter=0, last_data=0.
REQ-033 Reset asserted mid-access SHALL abandon the access with no done pulse; operation resumes in IDLE on the first edge after release.

Verification
REQ-034 Load with 0-wait memory: MemReadM=1, ALUresultM=0x100, mem_rdata=0xDEADBEEF, ack in cycle 1 -> mem_addr=0x100, mem_we=0, DataDoneM pulse in cycle 2, ReadDataM=0xDEADBEEF, StallM high in cycles 0-1 and low in cycle 2.
REQ-035 Simultaneous requests from reset: InstReqF and MemWriteM both 1, WriteDataM=0x12345678 -> data access first (mem_we=1, mem_wdata=0x12345678), then fetch; on the next tie, the fetch wins.
REQ-036 Memory never acks, TIMEOUT=15 -> mem_req high for exactly 15 cycles, then RESP; DataDoneM pulse with ReadDataM=0; BusErr=1 and stays 1 through later good accesses.
REQ-037 Ack in the same cycle the counter hits TIMEOUT-1 -> normal completion with captured data; BusErr stays 0.
REQ-038 RSTn pulsed low during a 3-wait fetch -> mem_req drops asynchronously, no InstValidF pulse, all outputs 0; the fetch reissues after release.
REQ-039 Fetch-only stream with 2 wait cycles, PCF=0x0,0x4,0x8 -> InstValidF every 5 cycles; InstrF matches each word; ReadDataM unchanged.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port memory between the fetch port and
// the MEM-stage load/store port. Fetch and data alternate on ties; an access
// that sees no mem_ack for TIMEOUT cycles is aborted with a sticky BusErr.
module dmem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        InstReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstValidF,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        DataDoneM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, nextState;
  logic        lastData;   // 1 when the most recent completed access was data
  logic        weReg;
  logic [7:0]  waitCnt;
  logic [31:0] addrReg, wdataReg;
  logic        dataReq, busy, timeout, finish, grantData, grantInst;

  // A load+store request is treated as a store; either one is a data request.
  assign dataReq   = MemReadM | MemWriteM;
  assign busy      = (state == INST) || (state == DATA);
  // Ack wins over a timeout landing in the same cycle.
  assign timeout   = busy && !mem_ack && (waitCnt == LAST_WAIT);
  assign finish    = busy && (mem_ack || timeout);
  // Tie goes to whichever side was not served last.
  assign grantData = (state == IDLE) && dataReq && (!InstReqF || !lastData);
  assign grantInst = (state == IDLE) && InstReqF && !grantData;

  assign StallM    = dataReq & ~DataDoneM;
  assign mem_addr  = addrReg;
  assign mem_wdata = wdataReg;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:       if (grantData) nextState = DATA;
                  else if (grantInst) nextState = INST;
      INST, DATA: if (finish) nextState = RESP;
      RESP:       nextState = IDLE;
      default:    nextState = IDLE;
    endcase
  end

  // Outputs decoded from state; lastData already names the finished access in RESP
  always_comb begin
    mem_req    = busy;
    mem_we     = (state == DATA) && weReg;
    InstValidF = (state == RESP) && !lastData;
    DataDoneM  = (state == RESP) && lastData;
  end

  // Capture the granted request; these drive the memory bus for the whole access
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      addrReg  <= '0;
      wdataReg <= '0;
      weReg    <= 1'b0;
    end else if (grantInst) begin
      addrReg  <= PCF;
      weReg    <= 1'b0;
    end else if (grantData) begin
      addrReg  <= ALUresultM;
      wdataReg <= WriteDataM;
      weReg    <= MemWriteM;
    end
  end

  // Wait counter: cleared on grant, counts cycles spent without an ack
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                    waitCnt <= '0;
    else if (grantInst || grantData) waitCnt <= '0;
    else if (busy && !mem_ack)    waitCnt <= waitCnt + 8'd1;
  end

  // Completion: results are loaded on the edge into RESP so they are valid
  // alongside the done pulse; a timed-out read returns zero.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      InstrF    <= '0;
      ReadDataM <= '0;
      lastData  <= 1'b0;
      BusErr    <= 1'b0;
    end else if (finish) begin
      lastData <= (state == DATA);
      if (timeout) BusErr <= 1'b1;
      if (state == INST)
        InstrF <= timeout ? 32'h0 : mem_rdata;
      else if (!weReg)
        ReadDataM <= timeout ? 32'h0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected responses,
// a monitor pops and compares on every InstValidF/DataDoneM pulse.
module tb_dmem_port_arbiter;
  localparam int TO = 15;

  logic        CLK = 1'b0, RSTn;
  logic        InstReqF = 0, MemReadM = 0, MemWriteM = 0;
  logic [31:0] PCF = 0, ALUresultM = 0, WriteDataM = 0;
  logic [31:0] InstrF, ReadDataM, mem_addr, mem_wdata;
  logic        InstValidF, DataDoneM, StallM, mem_req, mem_we, BusErr;
  logic        mem_ack = 0;
  logic [31:0] mem_rdata = 0;

  always #5 CLK = ~CLK;

  dmem_port_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .InstReqF(InstReqF), .PCF(PCF), .InstrF(InstrF), .InstValidF(InstValidF),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALUresultM(ALUresultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .DataDoneM(DataDoneM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .BusErr(BusErr)
  );

  typedef struct {
    logic        isData;
    logic [31:0] instr;
    logic [31:0] rdata;
    logic        busErr;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  int          nChecks = 0, nFails = 0;
  logic [31:0] expInstr = 0, expRead = 0;
  logic        expBusErr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks after memWait idle cycles, or never when memNoAck.
  int          memWait = 0, wc = 0, reqLen = 0;
  bit          memNoAck = 0;
  logic [31:0] seenAddr = 0, seenWdata = 0;
  logic        seenWe = 0;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction

  always @(negedge CLK) begin
    if (mem_req) begin
      reqLen++;
      seenAddr  = mem_addr;
      seenWe    = mem_we;
      seenWdata = mem_wdata;
      if (!memNoAck && wc == memWait) begin
        mem_ack   = 1'b1;
        mem_rdata = memFn(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        wc++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      wc        = 0;
    end
  end

  // Monitor: every done pulse must match the oldest expected response
  always @(negedge CLK) begin
    exp_t e;
    if (RSTn === 1'b1 && (InstValidF || DataDoneM)) begin
      if (sbq.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_done: InstValidF=%b DataDoneM=%b with empty scoreboard", InstValidF, DataDoneM);
      end else begin
        e = sbq.pop_front();
        chk("done_kind", 32'(DataDoneM), 32'(e.isData));
        chk("single_pulse", 32'(InstValidF & DataDoneM), 32'd0);
        chk("InstrF", InstrF, e.instr);
        chk("ReadDataM", ReadDataM, e.rdata);
        chk("BusErr", 32'(BusErr), 32'(e.busErr));
        chk("mem_addr", seenAddr, e.addr);
        chk("mem_we", 32'(seenWe), 32'(e.we));
        if (e.we) chk("mem_wdata", seenWdata, e.wdata);
      end
    end
  end

  task automatic pushExp(input logic isData, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd);
    exp_t e;
    if (!isData) expInstr = rd;
    else if (!we) expRead = rd;
    e.isData = isData; e.instr = expInstr; e.rdata = expRead; e.busErr = expBusErr;
    e.addr = addr; e.we = we; e.wdata = wdata;
    sbq.push_back(e);
  endtask

  // Returns the number of falling edges until a done pulse (bounded)
  task automatic waitDone(input int maxCyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!(InstValidF || DataDoneM) && cyc < maxCyc);
    if (!(InstValidF || DataDoneM)) begin
      nChecks++;
      nFails++;
      $display("FAIL done_wait: no done pulse within %0d cycles", maxCyc);
    end
  endtask

  task automatic resetDut();
    RSTn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    expInstr = 0; expRead = 0; expBusErr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    RSTn = 1'b1;
    #2 RSTn = 1'b0;
    #1;
    // reset state
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_InstrF", InstrF, 0);
    chk("rst_ReadDataM", ReadDataM, 0);
    chk("rst_pulses", 32'({InstValidF, DataDoneM}), 0);
    chk("rst_BusErr", 32'(BusErr), 0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    // zero-wait load
    memWait = 0;
    MemReadM = 1; ALUresultM = 32'h100;
    pushExp(1, 0, 32'h100, 0, 32'hDEADBEEF);
    #1 chk("load_StallM_c0", 32'(StallM), 1);
    @(negedge CLK);
    chk("load_StallM_c1", 32'(StallM), 1);
    chk("load_mem_req_c1", 32'(mem_req), 1);
    waitDone(10, c);
    chk("load_latency", 32'(c), 1);
    chk("load_StallM_c2", 32'(StallM), 0);
    MemReadM = 0;
    @(negedge CLK);

    // tie from reset: data first, then fetch; a fresh tie then goes to fetch
    resetDut();
    memWait = 1;
    InstReqF = 1; PCF = 32'h40;
    MemWriteM = 1; ALUresultM = 32'h200; WriteDataM = 32'h12345678;
    pushExp(1, 1, 32'h200, 32'h12345678, 0);
    pushExp(0, 0, 32'h40, 0, 32'hFFBF0040);
    pushExp(1, 0, 32'h204, 0, 32'hFDFB0204);
    waitDone(10, c);
    MemWriteM = 0; MemReadM = 1; ALUresultM = 32'h204;
    waitDone(10, c);
    chk("tie2_fetch_first", 32'(InstValidF), 1);
    InstReqF = 0;
    waitDone(10, c);
    MemReadM = 0;
    @(negedge CLK);

    // fetch stream, 2 wait cycles
    memWait = 2;
    InstReqF = 1; PCF = 32'h0;
    pushExp(0, 0, 32'h0, 0, 32'hFFFF0000);
    pushExp(0, 0, 32'h4, 0, 32'hFFFB0004);
    pushExp(0, 0, 32'h8, 0, 32'hFFF70008);
    for (int i = 0; i < 3; i++) begin
      waitDone(20, c);
      chk("fetch_period", 32'(c), (i == 0) ? 32'd4 : 32'd5);
      PCF = PCF + 32'h4;
      if (i == 2) InstReqF = 0;
    end
    @(negedge CLK);

    // ack lands on the last permitted wait cycle: normal completion
    memWait = TO - 1; reqLen = 0;
    MemReadM = 1; ALUresultM = 32'h300;
    pushExp(1, 0, 32'h300, 0, 32'hFCFF0300);
    waitDone(40, c);
    chk("edge_ack_latency", 32'(c), 16);
    chk("edge_ack_reqlen", 32'(reqLen), 15);
    MemReadM = 0;
    @(negedge CLK);

    // no ack at all: timeout, zero data, sticky BusErr
    memNoAck = 1; reqLen = 0;
    MemReadM = 1; ALUresultM = 32'h400;
    expBusErr = 1;
    pushExp(1, 0, 32'h400, 0, 32'h0);
    waitDone(40, c);
    chk("timeout_latency", 32'(c), 16);
    chk("timeout_reqlen", 32'(reqLen), 15);
    MemReadM = 0;
    memNoAck = 0; memWait = 0;
    @(negedge CLK);
    InstReqF = 1; PCF = 32'h10;
    pushExp(0, 0, 32'h10, 0, 32'hFFEF0010);
    waitDone(10, c);
    InstReqF = 0;
    MemReadM = 1; ALUresultM = 32'h100;
    pushExp(1, 0, 32'h100, 0, 32'hDEADBEEF);
    waitDone(10, c);
    MemReadM = 0;
    @(negedge CLK);

    // reset in the middle of a 3-wait fetch
    memWait = 3;
    InstReqF = 1; PCF = 32'hC;
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst_mem_req_before", 32'(mem_req), 1);
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_outputs", {InstrF[15:0] | ReadDataM[15:0] | mem_addr[15:0], 13'd0,
                           InstValidF, DataDoneM, BusErr}, 0);
    expInstr = 0; expRead = 0; expBusErr = 0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    pushExp(0, 0, 32'hC, 0, 32'hFFF3000C);
    waitDone(20, c);
    chk("reissue_latency", 32'(c), 5);
    InstReqF = 0;

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
